// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int MEM_LAT_MAX = 15;
    localparam int c_CNT_W     = 4;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester handshakes and memory port bundled for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_valid, d_gnt, d_valid, rdata,
               mem_addr, mem_wdata, mem_we, busy
    );

    // Requester / memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_valid, d_gnt, d_valid, rdata,
               mem_addr, mem_wdata, mem_we, busy
    );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational winner selection between fetch and data.
//               ROUND_ROBIN_EN selects alternating tie-break, else data wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  wire logic i_ifReq,
    input  wire logic i_dReq,
    input  owner_t    i_lastOwner,
    output owner_t    o_winner,
    output logic      o_anyReq
);

    assign o_anyReq = i_ifReq | i_dReq;

`ifdef ROUND_ROBIN_EN
    always_comb begin
        o_winner = OWN_IF;
        if (i_ifReq && i_dReq) begin
            // Tie goes to whoever was not served last
            o_winner = (i_lastOwner == OWN_D) ? OWN_IF : OWN_D;
        end else if (i_dReq) begin
            o_winner = OWN_D;
        end
    end
`else
    logic w_unusedLastOwner;
    assign w_unusedLastOwner = i_lastOwner;
    assign o_winner          = i_dReq ? OWN_D : OWN_IF;
`endif

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between fetch and load/store paths
//               via request/grant handshakes. Option macro: ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input wire logic         clk,
    input wire logic         rst,
    mem_port_arbiter_if.slave bus
);
    import mem_arb_pkg::*;

    localparam int c_LAT = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
                           ((MEM_LAT < 1) ? 1 : MEM_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_LAT - 1);

    state_t              r_state;
    state_t              w_nextState;
    owner_t              r_owner;
    owner_t              w_winner;
    logic                w_anyReq;
    logic                w_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_we;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                w_ifGnt;
    logic                w_dGnt;
    logic                w_ifValid;
    logic                w_dValid;
    logic                w_memWe;
    logic                w_busy;

    mem_arb_pick u_pick (
        .i_ifReq     (bus.if_req),
        .i_dReq      (bus.d_req),
        .i_lastOwner (r_owner),
        .o_winner    (w_winner),
        .o_anyReq    (w_anyReq)
    );

    assign w_grant = (r_state == IDLE) && w_anyReq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Stores load the counter with zero so every access exits on the same test
    always_comb begin
        w_nextState = r_state;
        w_ifGnt     = 1'b0;
        w_dGnt      = 1'b0;
        w_ifValid   = 1'b0;
        w_dValid    = 1'b0;
        w_memWe     = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_anyReq) begin
                    w_nextState = ACCESS;
                    w_ifGnt     = (w_winner == OWN_IF);
                    w_dGnt      = (w_winner == OWN_D);
                end
            end
            ACCESS: begin
                w_memWe = r_we;
                if (r_cnt == '0) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                w_nextState = IDLE;
                w_ifValid   = (r_owner == OWN_IF);
                w_dValid    = (r_owner == OWN_D);
            end
            default: begin
                w_nextState = IDLE;
                w_busy      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_D;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
        end else if (w_grant) begin
            r_owner <= w_winner;
            if (w_winner == OWN_D) begin
                r_addr  <= bus.d_addr;
                r_we    <= bus.d_we;
                r_wdata <= bus.d_wdata;
                r_cnt   <= bus.d_we ? '0 : c_CNT_LOAD;
            end else begin
                r_addr  <= bus.if_addr;
                r_we    <= 1'b0;
                r_cnt   <= c_CNT_LOAD;
            end
        end else if (r_state == ACCESS) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (!r_we) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_gnt    = w_ifGnt;
    assign bus.d_gnt     = w_dGnt;
    assign bus.if_valid  = w_ifValid;
    assign bus.d_valid   = w_dValid;
    assign bus.mem_we    = w_memWe;
    assign bus.busy      = w_busy;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.rdata     = r_rdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter at MEM_LAT 1, 2, 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int c_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nAssert = 0;
    int   nFail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b1 ();
    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b2 ();
    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b3 ();

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .bus(b1.slave));
    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(c_LAT)) u_lat2 (
        .clk(clk), .rst(rst), .bus(b2.slave));
    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .bus(b3.slave));

    // Memory content is a fixed function of address; 0x40 reads 0x00A00093
    function automatic logic [63:0] memFn(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A5A5A, a[31:0] ^ 32'h00A000D3};
    endfunction

    assign b1.mem_rdata = memFn(b1.mem_addr);
    assign b2.mem_rdata = memFn(b2.mem_addr);
    assign b3.mem_rdata = memFn(b3.mem_addr);

    task automatic clearInputs();
        b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
        b2.if_req = 0; b2.if_addr = '0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = '0; b2.d_wdata = '0;
        b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
    endtask

    task automatic pulseReset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nAssert++; if (b2.busy !== 1'b0) begin nFail++; $display("FAIL rst_busy: got %b expected 0", b2.busy); end
        nAssert++; if (b2.if_gnt !== 1'b0 || b2.d_gnt !== 1'b0) begin nFail++; $display("FAIL rst_gnt: got %b%b expected 00", b2.if_gnt, b2.d_gnt); end
        nAssert++; if (b2.if_valid !== 1'b0 || b2.d_valid !== 1'b0) begin nFail++; $display("FAIL rst_valid: got %b%b expected 00", b2.if_valid, b2.d_valid); end
        nAssert++; if (b2.mem_we !== 1'b0) begin nFail++; $display("FAIL rst_mem_we: got %b expected 0", b2.mem_we); end
        nAssert++; if (b2.rdata !== 64'h0) begin nFail++; $display("FAIL rst_rdata: got %h expected 0", b2.rdata); end
        nAssert++; if (b2.mem_addr !== 64'h0 || b2.mem_wdata !== 64'h0) begin nFail++; $display("FAIL rst_mem_bus: got %h/%h expected 0/0", b2.mem_addr, b2.mem_wdata); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_fetch();
        @(posedge clk); #1 b2.if_req = 1; b2.if_addr = 64'h40;
        @(negedge clk);
        nAssert++; if (b2.if_gnt !== 1'b1 || b2.d_gnt !== 1'b0) begin nFail++; $display("FAIL fetch_gnt: got if=%b d=%b expected if=1 d=0", b2.if_gnt, b2.d_gnt); end
        @(posedge clk); #1 b2.if_req = 0;
        @(negedge clk);
        nAssert++; if (b2.mem_addr !== 64'h40 || b2.busy !== 1'b1) begin nFail++; $display("FAIL fetch_t1: got addr=%h busy=%b expected 40/1", b2.mem_addr, b2.busy); end
        @(negedge clk);
        nAssert++; if (b2.mem_addr !== 64'h40 || b2.if_valid !== 1'b0) begin nFail++; $display("FAIL fetch_t2: got addr=%h valid=%b expected 40/0", b2.mem_addr, b2.if_valid); end
        @(negedge clk);
        nAssert++; if (b2.if_valid !== 1'b1 || b2.d_valid !== 1'b0) begin nFail++; $display("FAIL fetch_valid: got if=%b d=%b expected 1/0", b2.if_valid, b2.d_valid); end
        nAssert++; if (b2.rdata[31:0] !== 32'h00A00093) begin nFail++; $display("FAIL fetch_rdata: got %h expected 00a00093", b2.rdata[31:0]); end
        @(negedge clk);
        nAssert++; if (b2.busy !== 1'b0 || b2.if_valid !== 1'b0) begin nFail++; $display("FAIL fetch_idle: got busy=%b valid=%b expected 0/0", b2.busy, b2.if_valid); end
    endtask

    task automatic test_store();
        logic [63:0] prevRdata;
        prevRdata = memFn(64'h40);
        @(posedge clk); #1 b2.d_req = 1; b2.d_we = 1; b2.d_addr = 64'h100; b2.d_wdata = 64'hDEADBEEF;
        @(negedge clk);
        nAssert++; if (b2.d_gnt !== 1'b1 || b2.mem_we !== 1'b0) begin nFail++; $display("FAIL store_gnt: got gnt=%b we=%b expected 1/0", b2.d_gnt, b2.mem_we); end
        @(posedge clk); #1 b2.d_req = 0; b2.d_we = 0;
        @(negedge clk);
        nAssert++; if (b2.mem_we !== 1'b1 || b2.mem_addr !== 64'h100 || b2.mem_wdata !== 64'hDEADBEEF) begin nFail++; $display("FAIL store_t1: got we=%b addr=%h wdata=%h expected 1/100/deadbeef", b2.mem_we, b2.mem_addr, b2.mem_wdata); end
        nAssert++; if (b2.d_valid !== 1'b0) begin nFail++; $display("FAIL store_early_valid: got %b expected 0", b2.d_valid); end
        @(negedge clk);
        nAssert++; if (b2.mem_we !== 1'b0 || b2.d_valid !== 1'b1) begin nFail++; $display("FAIL store_t2: got we=%b valid=%b expected 0/1", b2.mem_we, b2.d_valid); end
        nAssert++; if (b2.rdata !== prevRdata) begin nFail++; $display("FAIL store_rdata: got %h expected %h", b2.rdata, prevRdata); end
        @(negedge clk);
        nAssert++; if (b2.busy !== 1'b0) begin nFail++; $display("FAIL store_idle: got busy=%b expected 0", b2.busy); end
    endtask

    task automatic test_priority();
        owner_t got[$];
        owner_t exp[3];
`ifdef ROUND_ROBIN_EN
        exp = '{OWN_IF, OWN_D, OWN_IF};
`else
        exp = '{OWN_D, OWN_D, OWN_D};
`endif
        pulseReset();
        b2.if_req = 1; b2.if_addr = 64'h80; b2.d_req = 1; b2.d_we = 0; b2.d_addr = 64'h88;
        for (int c = 0; c < 40 && got.size() < 3; c++) begin
            @(negedge clk);
            nAssert++; if (b2.if_gnt === 1'b1 && b2.d_gnt === 1'b1) begin nFail++; $display("FAIL tie_double_gnt: got both grants expected one"); end
            if (b2.if_gnt === 1'b1) got.push_back(OWN_IF);
            else if (b2.d_gnt === 1'b1) got.push_back(OWN_D);
        end
        @(posedge clk); #1 b2.if_req = 0; b2.d_req = 0;
        nAssert++; if (got.size() != 3) begin nFail++; $display("FAIL tie_count: got %0d grants expected 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            nAssert++; if (got[i] !== exp[i]) begin nFail++; $display("FAIL tie_order[%0d]: got %s expected %s", i, got[i].name(), exp[i].name()); end
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1
        b3.d_req = 1; b3.d_we = 0; b3.d_addr = 64'h200;
        b2.d_req = 1; b2.d_we = 1; b2.d_addr = 64'h300; b2.d_wdata = 64'h1234;
        @(negedge clk);
        nAssert++; if (b3.d_gnt !== 1'b1 || b2.d_gnt !== 1'b1) begin nFail++; $display("FAIL rmid_gnt: got %b%b expected 11", b3.d_gnt, b2.d_gnt); end
        @(posedge clk); #1 b3.d_req = 0; b2.d_req = 0; b2.d_we = 0;
        @(negedge clk);
        nAssert++; if (b3.busy !== 1'b1 || b2.mem_we !== 1'b1) begin nFail++; $display("FAIL rmid_access: got busy=%b we=%b expected 1/1", b3.busy, b2.mem_we); end
        #2 rst = 1'b1;
        #1;
        nAssert++; if (b3.busy !== 1'b0 || b2.busy !== 1'b0) begin nFail++; $display("FAIL rmid_async_busy: got %b%b expected 00", b3.busy, b2.busy); end
        nAssert++; if (b2.mem_we !== 1'b0) begin nFail++; $display("FAIL rmid_async_we: got %b expected 0", b2.mem_we); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        nAssert++; if (b3.d_valid !== 1'b0 || b2.d_valid !== 1'b0) begin nFail++; $display("FAIL rmid_no_valid: got %b%b expected 00", b3.d_valid, b2.d_valid); end
        @(posedge clk); #1 b3.d_req = 1; b3.d_we = 0; b3.d_addr = 64'h208;
        @(negedge clk);
        nAssert++; if (b3.d_gnt !== 1'b1 || b3.d_valid !== 1'b0) begin nFail++; $display("FAIL rmid_regrant: got gnt=%b valid=%b expected 1/0", b3.d_gnt, b3.d_valid); end
        @(posedge clk); #1 b3.d_req = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            nAssert++; if (b3.d_valid !== (c == 4)) begin nFail++; $display("FAIL rmid_valid_t%0d: got %b expected %b", c, b3.d_valid, (c == 4)); end
        end
        nAssert++; if (b3.rdata !== memFn(64'h208)) begin nFail++; $display("FAIL rmid_rdata: got %h expected %h", b3.rdata, memFn(64'h208)); end
    endtask

    task automatic test_resp_pulse();
        @(posedge clk); #1 b2.if_req = 1; b2.if_addr = 64'h80;
        @(negedge clk);
        nAssert++; if (b2.if_gnt !== 1'b1) begin nFail++; $display("FAIL rpulse_gnt: got %b expected 1", b2.if_gnt); end
        @(posedge clk); #1 b2.if_req = 0;
        repeat (2) @(posedge clk);
        #1 b2.d_req = 1; b2.d_we = 1; b2.d_addr = 64'h900; b2.d_wdata = 64'h55;
        @(negedge clk);
        nAssert++; if (b2.if_valid !== 1'b1 || b2.d_gnt !== 1'b0) begin nFail++; $display("FAIL rpulse_resp: got valid=%b dgnt=%b expected 1/0", b2.if_valid, b2.d_gnt); end
        @(posedge clk); #1 b2.d_req = 0; b2.d_we = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            nAssert++; if (b2.busy !== 1'b0 || b2.d_gnt !== 1'b0 || b2.mem_we !== 1'b0 || b2.mem_addr !== 64'h80) begin
                nFail++; $display("FAIL rpulse_idle%0d: got busy=%b gnt=%b we=%b addr=%h expected 0/0/0/80", c, b2.busy, b2.d_gnt, b2.mem_we, b2.mem_addr); end
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1 b1.d_req = 1; b1.d_we = 0; b1.d_addr = 64'h500;
        @(negedge clk);
        nAssert++; if (b1.d_gnt !== 1'b1) begin nFail++; $display("FAIL b2b_dgnt: got %b expected 1", b1.d_gnt); end
        @(posedge clk); #1 b1.d_req = 0;
        @(negedge clk);
        nAssert++; if (b1.busy !== 1'b1 || b1.mem_addr !== 64'h500 || b1.d_valid !== 1'b0) begin nFail++; $display("FAIL b2b_access: got busy=%b addr=%h valid=%b expected 1/500/0", b1.busy, b1.mem_addr, b1.d_valid); end
        @(posedge clk); #1 b1.if_req = 1; b1.if_addr = 64'h40;
        @(negedge clk);
        nAssert++; if (b1.d_valid !== 1'b1 || b1.if_gnt !== 1'b0) begin nFail++; $display("FAIL b2b_resp: got valid=%b ifgnt=%b expected 1/0", b1.d_valid, b1.if_gnt); end
        nAssert++; if (b1.rdata !== memFn(64'h500)) begin nFail++; $display("FAIL b2b_rdata: got %h expected %h", b1.rdata, memFn(64'h500)); end
        @(negedge clk);
        nAssert++; if (b1.if_gnt !== 1'b1) begin nFail++; $display("FAIL b2b_ifgnt: got %b expected 1", b1.if_gnt); end
        @(posedge clk); #1 b1.if_req = 0;
        repeat (2) @(negedge clk);
        nAssert++; if (b1.if_valid !== 1'b1 || b1.rdata[31:0] !== 32'h00A00093) begin nFail++; $display("FAIL b2b_ifvalid: got valid=%b data=%h expected 1/00a00093", b1.if_valid, b1.rdata[31:0]); end
    endtask

    // Transaction-level model: grant at cycle g; access lasts len cycles; response at g+len+1
    task automatic test_random();
        bit          ifHold, dHold, active, mWe, bothReq;
        int          gCyc, len, d;
        owner_t      mOwn, mLast, win;
        logic [63:0] mAddr, mWdata, mRdata;
        logic        eIfG, eDG, eIfV, eDV, eWe, eBusy;
        pulseReset();
        ifHold = 0; dHold = 0; active = 0; mLast = OWN_D; mRdata = '0;
        mWe = 0; gCyc = 0; len = 0; mOwn = OWN_D; mAddr = '0; mWdata = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            if (!ifHold || $urandom_range(0, 15) == 0) begin
                ifHold = ($urandom_range(0, 2) == 0);
                b2.if_addr = {$urandom(), $urandom()};
            end
            if (!dHold || $urandom_range(0, 15) == 0) begin
                dHold = ($urandom_range(0, 2) == 0);
                b2.d_we = $urandom_range(0, 1);
                b2.d_addr = {$urandom(), $urandom()};
                b2.d_wdata = {$urandom(), $urandom()};
            end
            b2.if_req = ifHold; b2.d_req = dHold;
            @(negedge clk);
            eIfG = 0; eDG = 0; eIfV = 0; eDV = 0; eWe = 0; eBusy = active;
            if (!active) begin
                if (ifHold || dHold) begin
                    bothReq = ifHold && dHold;
`ifdef ROUND_ROBIN_EN
                    win = bothReq ? ((mLast == OWN_D) ? OWN_IF : OWN_D) : (dHold ? OWN_D : OWN_IF);
`else
                    win = dHold ? OWN_D : OWN_IF;
`endif
                    active = 1; gCyc = cyc; mOwn = win; mLast = win;
                    mAddr  = (win == OWN_D) ? b2.d_addr : b2.if_addr;
                    mWe    = (win == OWN_D) && b2.d_we;
                    mWdata = b2.d_wdata;
                    len    = mWe ? 1 : c_LAT;
                    if (win == OWN_D) begin eDG = 1; dHold = 0; end
                    else begin eIfG = 1; ifHold = 0; end
                end
            end else begin
                d = cyc - gCyc;
                if (d <= len) begin
                    eWe = mWe;
                    nAssert++; if (b2.mem_addr !== mAddr) begin nFail++; $display("FAIL rnd_mem_addr c%0d: got %h expected %h", cyc, b2.mem_addr, mAddr); end
                    if (mWe) begin
                        nAssert++; if (b2.mem_wdata !== mWdata) begin nFail++; $display("FAIL rnd_mem_wdata c%0d: got %h expected %h", cyc, b2.mem_wdata, mWdata); end
                    end
                end else begin
                    if (mOwn == OWN_D) eDV = 1; else eIfV = 1;
                    if (!mWe) mRdata = memFn(mAddr);
                    active = 0;
                end
            end
            nAssert++; if ({b2.if_gnt, b2.d_gnt} !== {eIfG, eDG}) begin nFail++; $display("FAIL rnd_gnt c%0d: got %b%b expected %b%b", cyc, b2.if_gnt, b2.d_gnt, eIfG, eDG); end
            nAssert++; if ({b2.if_valid, b2.d_valid} !== {eIfV, eDV}) begin nFail++; $display("FAIL rnd_valid c%0d: got %b%b expected %b%b", cyc, b2.if_valid, b2.d_valid, eIfV, eDV); end
            nAssert++; if (b2.mem_we !== eWe || b2.busy !== eBusy) begin nFail++; $display("FAIL rnd_we_busy c%0d: got %b%b expected %b%b", cyc, b2.mem_we, b2.busy, eWe, eBusy); end
            nAssert++; if (b2.rdata !== mRdata) begin nFail++; $display("FAIL rnd_rdata c%0d: got %h expected %h", cyc, b2.rdata, mRdata); end
        end
        @(posedge clk); #1 b2.if_req = 0; b2.d_req = 0;
    endtask

    initial begin
        clearInputs();
        test_reset();
        test_fetch();
        test_store();
        test_priority();
        test_reset_mid();
        test_resp_pulse();
        test_back_to_back();
        test_random();
        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory of the multicycle core between the instruction-fetch path and the load/store path of the control FSM. The arbiter accepts one request at a time, drives the memory address, write-data and write-enable for the required number of cycles, and returns read data or a write acknowledgement to the winning requester. It sits between the control unit and the memory, and it replaces the direct MemRead/MemData_Read strobes with a request/grant handshake.

## Interface
- ADDR_W, 64: address width in bits.
- DATA_W, 64: data width in bits. Fetch uses `rdata[31:0]`.
- MEM_LAT, 2: memory read latency in cycles. Legal values are 1 to 15.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held until `if_gnt`.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted (one-cycle pulse).
- if_valid  out  1  fetch data valid on `rdata` (one-cycle pulse).
- d_req  in  1  data request; held until `d_gnt`.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data accepted (one-cycle pulse).
- d_valid  out  1  load data valid on `rdata`, or store completed (one-cycle pulse).
- rdata  out  DATA_W  registered read data.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States and transitions:
  - IDLE → ACCESS when any request is pending.
  - ACCESS → RESP when the counter expires.
  - RESP → IDLE, unconditionally.
- Grant (Mealy output, only in IDLE): `*_gnt` is asserted in the same cycle as the winning `*_req`. On that clock edge the arbiter latches the owner, address, `we` and wdata.
- Arbitration when both requests are pending: data wins.
- ACCESS for a load or fetch:
  - `mem_addr` holds the latched address for MEM_LAT cycles.
  - A down-counter is loaded with MEM_LAT−1 and steps down each cycle.
  - `mem_rdata` is captured into `rdata` on the edge that leaves ACCESS.
- ACCESS for a store lasts exactly 1 cycle, with `mem_we`=1 and `mem_wdata` = latched wdata. `rdata` is unchanged.
- RESP lasts 1 cycle: the owner's `*_valid`=1. No grant is issued in RESP.
- `mem_we` is 1 only during a store ACCESS cycle. `mem_addr` and `mem_wdata` hold their last values while idle.
- A request dropped before its grant is ignored. After the grant, request inputs are don't-care until `*_valid`.
- Reset values:
  - state = IDLE
  - all `*_gnt`, `*_valid`, `mem_we` and `busy` = 0
  - `rdata`, `mem_addr` and `mem_wdata` = 0
  - counter = 0
  - owner = data
- Reset mid-operation aborts the access immediately. No `*_valid` pulse follows, and `mem_we` falls asynchronously.

## Timing
- Grant at cycle T. ACCESS occupies T+1 to T+MEM_LAT. `*_valid` is asserted at T+MEM_LAT+1.
- Store: grant at T, `mem_we` at T+1, `d_valid` at T+2.
- The earliest next grant comes 1 cycle after RESP. Fetch-to-fetch throughput is one access per MEM_LAT+2 cycles.
- `rdata` stays stable from the `*_valid` cycle until the next read capture.
- The counter width is 4 bits. It never wraps: it is loaded only on grant and stops at 0.

## Configuration
- ROUND_ROBIN_EN defined: on a tie, the requester not served last wins. The last-owner flag resets to data, so the first tie goes to fetch. A single request is still granted immediately.
- ROUND_ROBIN_EN undefined: fixed priority, data over fetch. No last-owner flop is present.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum `{IDLE, ACCESS, RESP}`
  - the owner enum `{OWN_IF, OWN_D}`
  - the constant `MEM_LAT_MAX` = 15
- One sub-module, `mem_arb_pick`: the combinational winner selection from `if_req`, `d_req` and last owner. It contains the only `ROUND_ROBIN_EN` conditional.
- The FSM, counter and datapath registers stay in the top module.

## Test plan
- Fetch only, MEM_LAT=2, `if_addr`=0x40, `mem_rdata`=0x00A00093 → `if_gnt` at T, `mem_addr`=0x40 at T+1 and T+2, `if_valid` at T+3 with `rdata[31:0]`=0x00A00093.
- Store, `d_addr`=0x100, `d_wdata`=0xDEADBEEF → `mem_we`=1 only at T+1, `d_valid` at T+2, `rdata` unchanged.
- `if_req` and `d_req` both held high for 3 accesses:
  - without the macro: data granted each time.
  - with the macro: grants go fetch, data, fetch.
- `rst` asserted at T+1 of a load (MEM_LAT=3) → `busy`=0 immediately, no `d_valid`, and the next request is granted in the cycle after reset release.
- `d_req` pulsed for one cycle during RESP of a fetch → no grant, no memory activity, `busy` falls after RESP.
- MEM_LAT=1 load → `d_valid` at T+2. Then an immediate back-to-back fetch is granted at T+3.
